// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with a registered read port, occupancy
// count, programmable almost-full/almost-empty levels and sticky
// overflow/underflow error flags.
module sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] CNT_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AFULL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_accept;
    logic                  rd_accept;

    // Status flags are pure decodes of the registered count.
    assign full         = (count_q == CNT_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AFULL);
    assign almost_empty = (count_q <= CNT_AEMPTY);

    assign count     = count_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Next-state logic: acceptance from start-of-cycle flags, pointers, count, read word, errors.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;

        wr_accept   = wr_en && !full;
        rd_accept   = rd_en && !empty;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + CNT_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + CNT_ONE;
            rd_data_d  = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            rd_valid_d = 1'b1;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A fresh error wins over a simultaneous clear.
        overflow_d  = (overflow_q  && !err_clr) || (wr_en && full);
        underflow_d = (underflow_q && !err_clr) || (rd_en && empty);
    end

    // Control and read-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset so it maps onto RAM; emptiness is tracked by count/pointers alone.
        if (wr_accept && !rst) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

endmodule
